// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver
// state encoding and the sample-tick divider calculation.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // Clocks per 1/16-bit sample tick, never below one.
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OVERSAMPLE);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO shared by the UART paths. Owns occupancy,
// overrun detection and the simultaneous push/pop rules.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [AW:0]      count,
    output logic             overrun
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full     = (count == FULL_CNT);
    assign rd_valid = (count != '0);
    assign pop_ok   = pop & rd_valid;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_ok  = push & (~full | pop_ok);
    assign rd_data  = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push & ~push_ok;
            if (push_ok) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop_ok) rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchroniser, 16x oversampling tick generator and frame FSM
// feeding a show-ahead byte FIFO with valid/ready read side.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int PARITY       = 0,
    parameter int FIFO_AW      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [FIFO_AW:0]   count,
    output logic               overrun,
    output logic               frame_err,
    output logic               parity_err
);

    localparam int DIV = calc_div(SYS_CLK_FREQ, BAUD_RATE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [1:0]    sync_pipe;
    logic          rx_s;
    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    tcnt;
    logic          mid;
    logic          start_det;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bad;
    logic          exp_par;
    logic          push_c;
    logic          ferr_c;
    logic          perr_c;
    logic          push_q;

    assign rx_s      = sync_pipe[1];
    assign tick      = (div_cnt == DW'(DIV - 1));
    assign mid       = tick && (tcnt == 4'd7);
    assign start_det = (state == S_IDLE) && !rx_s;
    assign exp_par   = (PARITY == PARITY_ODD) ? ~(^shift) : (^shift);

    always_ff @(posedge clk) begin
        if (!rst) sync_pipe <= 2'b11;
        else      sync_pipe <= {sync_pipe[0], rx};
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (!rx_s) state_nx = S_START;
            S_START:  if (mid) state_nx = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (mid && bit_idx == 3'd7)
                          state_nx = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (mid) state_nx = S_STOP;
            S_STOP:   if (mid) state_nx = rx_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx_s) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // A low stop bit wins over a parity mismatch: only frame_err fires.
    always_comb begin
        push_c = 1'b0;
        ferr_c = 1'b0;
        perr_c = 1'b0;
        if (state == S_STOP && mid) begin
            push_c = rx_s & ~par_bad;
            perr_c = rx_s & par_bad;
            ferr_c = ~rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt    <= '0;
            tcnt       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            push_q     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (start_det) begin
                div_cnt <= '0;
                tcnt    <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) tcnt <= tcnt + 4'd1;
            end
            if (state == S_START && mid) begin
                bit_idx <= '0;
                par_bad <= 1'b0;
            end
            if (state == S_DATA && mid) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
            if (state == S_PARITY && mid) par_bad <= (rx_s != exp_par);
            push_q     <= push_c;
            frame_err  <= ferr_c;
            parity_err <= perr_c;
        end
    end

    // shift stays stable until the next frame's data bits, so it can feed the
    // FIFO one clock after the stop sample.
    sync_fifo #(
        .WIDTH(8),
        .AW   (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_q),
        .push_data(shift),
        .pop      (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a no-parity and an even-parity receiver at
// 16 clocks per bit, driven by a table of frames plus hand-written corner cases.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx0, rx2;
    logic       rd_ready0, rd_ready2;
    logic [7:0] rd_data0, rd_data2;
    logic       rd_valid0, rd_valid2;
    logic [3:0] count0, count2;
    logic       ovr0, ovr2, fe0, fe2, pe0, pe2;

    int checks = 0;
    int failures = 0;
    int n_fe0 = 0, n_fe2 = 0, n_pe0 = 0, n_pe2 = 0, n_ov0 = 0, n_ov2 = 0;
    logic vld_at, vld_after;

    always #5 clk = ~clk;

    uart_rx #(.SYS_CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(0), .FIFO_AW(3)) dut (
        .clk(clk), .rst(rst), .rx(rx0), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .rd_ready(rd_ready0), .count(count0), .overrun(ovr0), .frame_err(fe0),
        .parity_err(pe0)
    );

    uart_rx #(.SYS_CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(2), .FIFO_AW(3)) dut_e (
        .clk(clk), .rst(rst), .rx(rx2), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .rd_ready(rd_ready2), .count(count2), .overrun(ovr2), .frame_err(fe2),
        .parity_err(pe2)
    );

    always @(posedge clk) begin
        if (fe0)  n_fe0 <= n_fe0 + 1;
        if (fe2)  n_fe2 <= n_fe2 + 1;
        if (pe0)  n_pe0 <= n_pe0 + 1;
        if (pe2)  n_pe2 <= n_pe2 + 1;
        if (ovr0) n_ov0 <= n_ov0 + 1;
        if (ovr2) n_ov2 <= n_ov2 + 1;
    end

    typedef struct {
        bit         line;      // 0: no-parity DUT, 1: even-parity DUT
        logic [7:0] data;
        bit         par_en;
        bit         par_bit;
        bit         stop_bit;
        int         hold_low;  // extra clocks the line stays at the stop level
        bit         exp_push;
        int         exp_fe;
        int         exp_pe;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input bit line, input logic v);
        if (line) rx2 = v;
        else      rx0 = v;
    endtask

    function automatic logic cur_valid(input bit line);
        return line ? rd_valid2 : rd_valid0;
    endfunction

    function automatic int cur_count(input bit line);
        return line ? int'(count2) : int'(count0);
    endfunction

    function automatic int cur_data(input bit line);
        return line ? int'(rd_data2) : int'(rd_data0);
    endfunction

    // Drives one frame, 16 clocks per bit. Records rd_valid at the stop-sample
    // edge (11 clocks into the stop bit) and one clock later; optionally pulses
    // rd_ready on line 0 for exactly the cycle of the resulting push.
    task automatic send_frame(input bit line, input logic [7:0] d, input bit par_en,
                              input bit par_bit, input bit stop_bit, input int hold_low,
                              input bit pop_at_push);
        set_rx(line, 1'b0);
        tick(16);
        for (int b = 0; b < 8; b++) begin
            set_rx(line, d[b]);
            tick(16);
        end
        if (par_en) begin
            set_rx(line, par_bit);
            tick(16);
        end
        set_rx(line, stop_bit);
        for (int j = 1; j <= 16; j++) begin
            tick();
            if (j == 11) begin
                vld_at = cur_valid(line);
                if (pop_at_push) rd_ready0 = 1'b1;
            end
            if (j == 12) begin
                vld_after = cur_valid(line);
                rd_ready0 = 1'b0;
            end
        end
        tick(hold_low);
        set_rx(line, 1'b1);
        tick(24);
    endtask

    task automatic pop(input bit line);
        if (line) rd_ready2 = 1'b1;
        else      rd_ready0 = 1'b1;
        tick();
        rd_ready0 = 1'b0;
        rd_ready2 = 1'b0;
    endtask

    initial begin
        int fe_b, pe_b, ov_b;
        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 0,  1'b1, 0, 0};
        vecs[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 0,  1'b1, 0, 0};
        vecs[2] = '{1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 40, 1'b0, 1, 0};
        vecs[3] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 0,  1'b1, 0, 0};
        vecs[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 0,  1'b1, 0, 0};
        vecs[5] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 0,  1'b0, 0, 1};
        vecs[6] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1, 0};
        vecs[7] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 0,  1'b1, 0, 0};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0,  1'b1, 0, 0};
        vecs[9] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 0,  1'b1, 0, 0};

        rst = 1'b0; rx0 = 1'b1; rx2 = 1'b1; rd_ready0 = 1'b0; rd_ready2 = 1'b0;
        tick(3);
        chk("reset_valid0", int'(rd_valid0), 0);
        chk("reset_count0", int'(count0), 0);
        chk("reset_data0",  int'(rd_data0), 0);
        chk("reset_valid2", int'(rd_valid2), 0);
        chk("reset_count2", int'(count2), 0);
        chk("reset_pulses", int'({ovr0, fe0, pe0, ovr2, fe2, pe2}), 0);
        rst = 1'b1;
        tick(20);

        // Low pulse far shorter than half a bit is rejected silently.
        fe_b = n_fe0; pe_b = n_pe0;
        rx0 = 1'b0;
        tick(4);
        rx0 = 1'b1;
        tick(30);
        chk("glitch_count", int'(count0), 0);
        chk("glitch_fe", n_fe0 - fe_b, 0);
        chk("glitch_pe", n_pe0 - pe_b, 0);

        foreach (vecs[i]) begin
            fe_b = vecs[i].line ? n_fe2 : n_fe0;
            pe_b = vecs[i].line ? n_pe2 : n_pe0;
            send_frame(vecs[i].line, vecs[i].data, vecs[i].par_en, vecs[i].par_bit,
                       vecs[i].stop_bit, vecs[i].hold_low, 1'b0);
            chk($sformatf("v%0d_count", i), cur_count(vecs[i].line), int'(vecs[i].exp_push));
            chk($sformatf("v%0d_fe", i), (vecs[i].line ? n_fe2 : n_fe0) - fe_b, vecs[i].exp_fe);
            chk($sformatf("v%0d_pe", i), (vecs[i].line ? n_pe2 : n_pe0) - pe_b, vecs[i].exp_pe);
            if (vecs[i].exp_push) begin
                chk($sformatf("v%0d_data", i), cur_data(vecs[i].line), int'(vecs[i].data));
                chk($sformatf("v%0d_lat", i), int'({vld_at, vld_after}), 1);
                pop(vecs[i].line);
                chk($sformatf("v%0d_popped", i), cur_count(vecs[i].line), 0);
            end
        end

        // Fill past capacity: ninth byte dropped with a single overrun.
        ov_b = n_ov0;
        for (int b = 0; b < 8; b++) send_frame(1'b0, 8'(b), 1'b0, 1'b0, 1'b1, 0, 1'b0);
        chk("fill_count", int'(count0), 8);
        chk("fill_ovr", n_ov0 - ov_b, 0);
        send_frame(1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        chk("full_count", int'(count0), 8);
        chk("full_ovr", n_ov0 - ov_b, 1);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("drain_%0d", b), int'(rd_data0), b);
            pop(1'b0);
        end
        chk("drain_empty", int'(rd_valid0), 0);

        // Full FIFO with a pop landing on the push cycle.
        for (int b = 0; b < 8; b++) send_frame(1'b0, 8'h10 + 8'(b), 1'b0, 1'b0, 1'b1, 0, 1'b0);
        ov_b = n_ov0;
        send_frame(1'b0, 8'h18, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        chk("pp_count", int'(count0), 8);
        chk("pp_ovr", n_ov0 - ov_b, 0);
        chk("pp_head", int'(rd_data0), 8'h11);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("pp_drain_%0d", b), int'(rd_data0), 8'h11 + b);
            pop(1'b0);
        end

        // Reset in the middle of a frame with a byte already buffered.
        send_frame(1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        chk("pre_rst_count", int'(count0), 1);
        fe_b = n_fe0; pe_b = n_pe0;
        rx0 = 1'b0;
        tick(40);
        rst = 1'b0;
        tick();
        chk("rst_count", int'(count0), 0);
        chk("rst_valid", int'(rd_valid0), 0);
        chk("rst_data", int'(rd_data0), 0);
        rst = 1'b1;
        rx0 = 1'b1;
        tick(200);
        chk("rst_no_fe", n_fe0 - fe_b, 0);
        chk("rst_no_pe", n_pe0 - pe_b, 0);
        chk("rst_idle_count", int'(count0), 0);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        chk("post_rst_count", int'(count0), 1);
        chk("post_rst_data", int'(rd_data0), 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
